// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the LEGv8 writeback
//                sequencer: FSM state encoding, the zero-register address
//                and the writeback Mux2 select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB       = 2'd2
  } wb_state_e;

  // Writes to X31 (XZR) are discarded by the register file.
  localparam logic [4:0] XZR_ADDR = 5'd31;

  // Mux2 select: 1 picks data_mem_in, 0 picks alu_in.
  localparam logic MUX_SEL_MEM = 1'b1;
  localparam logic MUX_SEL_ALU = 1'b0;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timeout_ctr
//  Description : Clear/enable up-counter that flags its terminal count
//                (TIMEOUT-1). Used to bound the data-memory wait.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-high reset
//                i_clr - synchronous clear (wins over i_en)
//                i_en  - count enable
//                o_tc  - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] c_term = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == c_term);

endmodule : wb_timeout_ctr
`default_nettype wire

// File: rtl/wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sequencer
//  Description : Writeback sequencer for the LEGv8 datapath. Accepts one
//                decoded instruction at a time, runs the data-memory
//                handshake for loads/stores, latches the ALU result and load
//                data, and drives the writeback Mux2 select and the
//                register-file write enable.
//  Ports       : clk, rst               - clock / async active-high reset
//                valid_in, ready_in     - instruction handshake
//                is_load, is_store,
//                reg_wr_in, rd_in,
//                alu_result             - decoded instruction fields
//                mem_req, mem_we,
//                mem_ack, mem_rdata     - data-memory handshake
//                wb_alu_data,
//                wb_mem_data            - Mux2 data inputs (latched)
//                mux_2_control          - Mux2 select (1 = memory data)
//                reg_write, wb_rd       - register-file write port control
//                mem_err                - one-cycle pulse on memory timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              reg_wr_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wb_alu_data,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic              mux_2_control,
  output logic              reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic              mem_err
);

  localparam logic [REG_AW-1:0] c_xzr = REG_AW'(XZR_ADDR);

  wb_state_e r_state;
  logic      r_op_store;   // current memory op is a store (no writeback)

  logic w_accept;
  logic w_in_wait;
  logic w_tc;
  logic w_ctr_clr;

  assign ready_in  = (r_state == IDLE);
  assign w_accept  = valid_in && ready_in;
  assign w_in_wait = (r_state == MEM_WAIT);

  // Counter runs only while waiting and is cleared whenever the wait ends,
  // so every memory op starts its timeout window from zero.
  assign w_ctr_clr = w_in_wait && (mem_ack || w_tc);

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_ctr_clr),
    .i_en  (w_in_wait),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_op_store    <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mux_2_control <= MUX_SEL_ALU;
      reg_write     <= 1'b0;
      mem_err       <= 1'b0;
      wb_rd         <= '0;
      wb_alu_data   <= '0;
      wb_mem_data   <= '0;
    end else begin
      mem_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            wb_rd       <= rd_in;
            wb_alu_data <= alu_result;
            if (is_load) begin
              r_state       <= MEM_WAIT;
              r_op_store    <= 1'b0;
              mem_req       <= 1'b1;
              mem_we        <= 1'b0;
              mux_2_control <= MUX_SEL_MEM;
            end else if (is_store) begin
              r_state    <= MEM_WAIT;
              r_op_store <= 1'b1;
              mem_req    <= 1'b1;
              mem_we     <= 1'b1;
            end else if (reg_wr_in) begin
              r_state       <= WB;
              mux_2_control <= MUX_SEL_ALU;
              // Register the enable on entry so it is high only in WB.
              reg_write     <= (rd_in != c_xzr);
            end
          end
        end

        MEM_WAIT: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (r_op_store) begin
              r_state <= IDLE;
            end else begin
              wb_mem_data <= mem_rdata;
              r_state     <= WB;
              reg_write   <= (wb_rd != c_xzr);
            end
          end else if (w_tc) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_err       <= 1'b1;
            mux_2_control <= MUX_SEL_ALU;
            r_state       <= IDLE;
          end
        end

        WB: begin
          reg_write     <= 1'b0;
          mux_2_control <= MUX_SEL_ALU;
          r_state       <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : wb_sequencer
`default_nettype wire
